btn_conditioner: RTL

//   Conditions the four raw push-buttons (btnU/btnD/btnL/btnR) before they reach lab4_top logic.
//   Per button: 2-flop synchronizer, counter debouncer, then a press/release/auto-repeat FSM.

---
 rtl/btn_pkg.sv | 22 ++
 rtl/btn_channel.sv | 127 ++++++++++++
 rtl/btn_conditioner.sv | 40 ++++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button conditioning chain.
package btn_pkg;

   typedef enum logic [1:0] {
      REL   = 2'd0,
      DELAY = 2'd1,
      RPT   = 2'd2
   } rpt_state_e;

   localparam int BTN_U = 3;
   localparam int BTN_D = 2;
   localparam int BTN_L = 1;
   localparam int BTN_R = 0;

   // 100 MHz defaults: 10 ms debounce, 500 ms first repeat, 100 ms repeat period.
   localparam int DEF_NBTN         = 4;
   localparam int DEF_DB_CYCLES    = 1_000_000;
   localparam int DEF_REPEAT_DELAY = 50_000_000;
   localparam int DEF_REPEAT_RATE  = 10_000_000;
   localparam int DEF_CNT_W        = 27;

endpackage

// File: rtl/btn_channel.sv
// One button: 2-flop synchronizer, counter debouncer and press/release/auto-repeat FSM.
module btn_channel
   import btn_pkg::*;
#(
   parameter int DB_CYCLES    = DEF_DB_CYCLES,
   parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
   parameter int REPEAT_RATE  = DEF_REPEAT_RATE,
   parameter int CNT_W        = DEF_CNT_W
) (
   input  logic clk,
   input  logic clr,
   input  logic raw_i,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic repeat_o
);

   localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RR_LAST  = CNT_W'(REPEAT_RATE - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             s1_q, s2_q;
   logic             level_q, level_d;
   logic [CNT_W-1:0] dcnt_q, dcnt_d;
   logic [CNT_W-1:0] rcnt_q, rcnt_d;
   rpt_state_e       state_q, state_d;
   logic             press_q, press_d;
   logic             release_q, release_d;
   logic             repeat_q, repeat_d;
   logic             rise, fall;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         s1_q      <= 1'b0;
         s2_q      <= 1'b0;
         level_q   <= 1'b0;
         dcnt_q    <= '0;
         rcnt_q    <= '0;
         state_q   <= REL;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         repeat_q  <= 1'b0;
      end else begin
         s1_q      <= raw_i;
         s2_q      <= s1_q;
         level_q   <= level_d;
         dcnt_q    <= dcnt_d;
         rcnt_q    <= rcnt_d;
         state_q   <= state_d;
         press_q   <= press_d;
         release_q <= release_d;
         repeat_q  <= repeat_d;
      end
   end

   // Any cycle where the synchronized input agrees with the level restarts the count.
   always_comb begin
      level_d = level_q;
      dcnt_d  = '0;
      if (s2_q != level_q) begin
         if (dcnt_q == DB_LAST) begin
            level_d = s2_q;
         end else begin
            dcnt_d = dcnt_q + CNT_ONE;
         end
      end
   end

   // Edges are taken from the next level so pulses land in the cycle the level changes.
   assign rise = level_d & ~level_q;
   assign fall = ~level_d & level_q;

   always_comb begin
      state_d   = state_q;
      rcnt_d    = rcnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      repeat_d  = 1'b0;
      case (state_q)
         REL: begin
            if (rise) begin
               press_d  = 1'b1;
               repeat_d = 1'b1;
               rcnt_d   = '0;
               state_d  = DELAY;
            end
         end
         DELAY: begin
            if (fall) begin
               release_d = 1'b1;
               rcnt_d    = '0;
               state_d   = REL;
            end else if (rcnt_q == RD_LAST) begin
               repeat_d = 1'b1;
               rcnt_d   = '0;
               state_d  = RPT;
            end else begin
               rcnt_d = rcnt_q + CNT_ONE;
            end
         end
         RPT: begin
            if (fall) begin
               release_d = 1'b1;
               rcnt_d    = '0;
               state_d   = REL;
            end else if (rcnt_q == RR_LAST) begin
               repeat_d = 1'b1;
               rcnt_d   = '0;
            end else begin
               rcnt_d = rcnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = REL;
            rcnt_d  = '0;
         end
      endcase
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;
   assign repeat_o  = repeat_q;

endmodule

// File: rtl/btn_conditioner.sv
// Conditions NBTN raw push-buttons into debounced levels and press/release/repeat pulses.
module btn_conditioner
   import btn_pkg::*;
#(
   parameter int NBTN         = DEF_NBTN,
   parameter int DB_CYCLES    = DEF_DB_CYCLES,
   parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
   parameter int REPEAT_RATE  = DEF_REPEAT_RATE,
   parameter int CNT_W        = DEF_CNT_W
) (
   input  logic            clk,
   input  logic            clr,
   input  logic [NBTN-1:0] btn_raw,
   output logic [NBTN-1:0] btn_level,
   output logic [NBTN-1:0] btn_press,
   output logic [NBTN-1:0] btn_release,
   output logic [NBTN-1:0] btn_repeat
);

   genvar gi;
   generate
      for (gi = 0; gi < NBTN; gi++) begin : g_chan
         btn_channel #(
            .DB_CYCLES    (DB_CYCLES),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE),
            .CNT_W        (CNT_W)
         ) u_chan (
            .clk       (clk),
            .clr       (clr),
            .raw_i     (btn_raw[gi]),
            .level_o   (btn_level[gi]),
            .press_o   (btn_press[gi]),
            .release_o (btn_release[gi]),
            .repeat_o  (btn_repeat[gi])
         );
      end
   endgenerate

endmodule
